// File: rtl/interpol_pkg.sv
// Shared widths, divider state encoding and output saturation for the multi-channel interpolator.
package interpol_pkg;

  localparam int unsigned DW  = 18;
  localparam int unsigned NFW = 4;
  localparam int unsigned NCH = 2;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned nfw);
    return dw + nfw + 1;
  endfunction

  function automatic int unsigned result_latency(input int unsigned nch, input int unsigned accw);
    return nch * (accw + 1) + 1;
  endfunction

  localparam int unsigned ACCW = acc_width(DW, NFW);
  localparam int unsigned LAT  = result_latency(NCH, ACCW);
  localparam int unsigned CNTW = $clog2(ACCW);
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} div_state_e;

  localparam logic signed [ACCW:0] SAT_HI = (ACCW + 1)'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW:0] SAT_LO = ~SAT_HI;

  // Clamp a signed quotient into the DW-bit sample range.
  function automatic logic signed [DW-1:0] sat(input logic signed [ACCW:0] x);
    if (x > SAT_HI) return DW'(SAT_HI);
    else if (x < SAT_LO) return DW'(SAT_LO);
    else return DW'(x);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider with sign applied on the last step; LOAD + (ACCW-1) ITER + DONE per quotient.
module seq_divider
  import interpol_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ACCW-1:0]        mag,
  input  logic                   neg,
  input  logic [NFW-1:0]         divisor,
  output logic                   done_c,
  output logic signed [DW-1:0]   quot_c
);

  div_state_e            state_q, state_d;
  logic [ACCW-1:0]       dvd_q, dvd_d;
  logic [ACCW-1:0]       quo_q, quo_d;
  logic [NFW-1:0]        dvs_q, dvs_d;
  logic [NFW-1:0]        rem_q, rem_d;
  logic                  neg_q, neg_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;

  logic [NFW:0]          rsh, rnew;
  logic                  ge;
  logic [ACCW-1:0]       qfin;
  logic signed [ACCW:0]  qsgn;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    done_c  = 1'b0;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    rsh    = {rem_q, dvd_q[ACCW-1]};
    ge     = (rsh >= {1'b0, dvs_q});
    rnew   = ge ? (rsh - {1'b0, dvs_q}) : rsh;
    qfin   = ACCW'({quo_q, ge});
    qsgn   = neg_q ? -$signed({1'b0, qfin}) : $signed({1'b0, qfin});
    quot_c = sat(qsgn);

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        dvd_d   = mag;
        dvs_d   = divisor;
        neg_d   = neg;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        rem_d = NFW'(rnew);
        dvd_d = dvd_q << 1;
        quo_d = qfin;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(ACCW - 2)) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = start ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/interpol_mc_seq.sv
// Multi-channel linear interpolator: per-channel differentiator/integrator, one shared divider by Nfreq.
// Optional INTERPOL_ROUND_EN: round half away from zero instead of truncating.
module interpol_mc_seq
  import interpol_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                endatain,
  input  logic                endataout,
  input  logic [NFW-1:0]      Nfreq,
  input  logic [NCH*DW-1:0]   datain,
  output logic [NCH*DW-1:0]   dataout,
  output logic                dout_valid,
  output logic                busy,
  output logic                overrun
);

  logic signed [DW-1:0]    old_q  [NCH];
  logic signed [DW-1:0]    old_d  [NCH];
  logic signed [ACCW-1:0]  acc_q  [NCH];
  logic signed [ACCW-1:0]  acc_d  [NCH];
  logic signed [ACCW-1:0]  snap_q [NCH];
  logic signed [ACCW-1:0]  snap_d [NCH];
  logic signed [DW:0]      diff_c [NCH];

  logic [NFW-1:0]          nfr_q, nfr_d;
  logic [NFW-1:0]          nfs_q, nfs_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic [NCH*DW-1:0]       hold_q, hold_d;
  logic [NCH*DW-1:0]       dataout_q, dataout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic                    start_c, last_c, kick_c, neg_c, div_done_c;
  logic signed [ACCW-1:0]  cur_c;
  logic [ACCW-1:0]         mag_c;
  logic signed [DW-1:0]    quot_c;

  seq_divider u_div (
    .clock   (clock),
    .reset   (reset),
    .start   (kick_c),
    .mag     (mag_c),
    .neg     (neg_c),
    .divisor (nfs_q),
    .done_c  (div_done_c),
    .quot_c  (quot_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        old_q[k]  <= '0;
        acc_q[k]  <= '0;
        snap_q[k] <= '0;
      end
      nfr_q        <= '0;
      nfs_q        <= '0;
      ch_q         <= '0;
      hold_q       <= '0;
      dataout_q    <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      old_q        <= old_d;
      acc_q        <= acc_d;
      snap_q       <= snap_d;
      nfr_q        <= nfr_d;
      nfs_q        <= nfs_d;
      ch_q         <= ch_d;
      hold_q       <= hold_d;
      dataout_q    <= dataout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    old_d        = old_q;
    acc_d        = acc_q;
    snap_d       = snap_q;
    nfr_d        = nfr_q;
    nfs_d        = nfs_q;
    ch_d         = ch_q;
    hold_d       = hold_q;
    dataout_d    = dataout_q;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    overrun_d    = overrun_q;

    start_c = endataout && !busy_q;
    last_c  = (ch_q == CHW'(NCH - 1));
    kick_c  = start_c || (div_done_c && !last_c);

    // Divider operands: magnitude and sign of the snapshot for the channel in flight.
    cur_c = snap_q[ch_q];
    neg_c = cur_c[ACCW-1];
    mag_c = neg_c ? ACCW'(-cur_c) : ACCW'(cur_c);
`ifdef INTERPOL_ROUND_EN
    mag_c = mag_c + ACCW'(nfs_q >> 1);
`endif

    for (int k = 0; k < NCH; k++) begin
      diff_c[k] = (DW + 1)'($signed(datain[k*DW +: DW])) - (DW + 1)'(old_q[k]);
      if (endataout) acc_d[k] = acc_q[k] + ACCW'(diff_c[k]);
      if (endatain)  old_d[k] = $signed(datain[k*DW +: DW]);
    end

    if (start_c) begin
      snap_d = acc_q;
      nfs_d  = (Nfreq == '0) ? NFW'(1) : Nfreq;
      busy_d = 1'b1;
      ch_d   = '0;
    end

    if (endataout && busy_q) overrun_d = 1'b1;

    // Quotients shift in from the top so channel 0 lands in the lowest slot after the last one.
    if (div_done_c) begin
      hold_d = (NCH * DW)'({quot_c, hold_q} >> DW);
      if (last_c) begin
        dataout_d    = hold_d;
        dout_valid_d = 1'b1;
        busy_d       = 1'b0;
        ch_d         = '0;
      end else begin
        ch_d = ch_q + CHW'(1);
      end
    end

    if (Nfreq != nfr_q) begin
      nfr_d = Nfreq;
      for (int k = 0; k < NCH; k++) begin
        acc_d[k] = '0;
        old_d[k] = '0;
      end
    end
  end

  assign dataout    = dataout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
